// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sequencer for a 3-tap FIR core with shadow coefficients, drain/commit and a credit-managed output FIFO.
// Optional handshake counter port out_count under `FIR_SEQ_CTRL_STATS_EN.
module fir_seq_ctrl #(
    parameter int DATA_W    = 8,
    parameter int LATENCY   = 2,
    parameter int DRAIN_LEN = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic              cfg_busy,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              fir_ce,
    output logic [DATA_W-1:0] fir_x,
    output logic [DATA_W-1:0] fir_a,
    output logic [DATA_W-1:0] fir_b,
    output logic [DATA_W-1:0] fir_c,
`ifdef FIR_SEQ_CTRL_STATS_EN
    output logic [15:0]       out_count,
`endif
    input  logic [DATA_W-1:0] fir_y
);
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int DW = $clog2(DRAIN_LEN);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, SWAP} state_t;

    state_t            state;
    logic [DATA_W-1:0] sa, sb, sc;
    logic [DATA_W-1:0] mem [OUT_DEPTH];
    logic [AW-1:0]     wp, rp;
    logic [AW:0]       cnt, credits;
    logic [LATENCY-1:0] tags;
    logic [DW-1:0]     dcnt;
    logic              pend, accept, push, pop, commit, drain_done;

    always_comb begin
        cfg_busy   = state == DRAIN || state == SWAP;
        s_ready    = state == RUN && !flush && credits < (AW+1)'(OUT_DEPTH);
        accept     = s_valid && s_ready;
        fir_ce     = accept || state == DRAIN;
        fir_x      = accept ? s_data : '0;
        commit     = cfg_we && cfg_addr == 2'd3 && !cfg_busy;
        drain_done = state == DRAIN && dcnt == DW'(DRAIN_LEN - 1);
        push       = fir_ce && tags[LATENCY-1];
        m_valid    = cnt != '0;
        pop        = m_valid && m_ready;
        m_data     = mem[rp];
    end

    always_ff @(posedge clk)
        if (push) mem[wp] <= fir_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sa      <= '0;
            sb      <= '0;
            sc      <= '0;
            fir_a   <= '0;
            fir_b   <= '0;
            fir_c   <= '0;
            pend    <= 1'b0;
            dcnt    <= '0;
            tags    <= '0;
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            credits <= '0;
        end else begin
            if (cfg_we && !cfg_busy && cfg_addr == 2'd0) sa <= cfg_wdata;
            if (cfg_we && !cfg_busy && cfg_addr == 2'd1) sb <= cfg_wdata;
            if (cfg_we && !cfg_busy && cfg_addr == 2'd2) sc <= cfg_wdata;
            // a 1 marks a real sample; drain zeros travel as 0 so their results are dropped
            if (fir_ce) tags <= (tags << 1) | LATENCY'(accept);
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt     <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            credits <= credits + (AW+1)'(accept) - (AW+1)'(pop);
            case (state)
                IDLE: if (commit) state <= SWAP;
                RUN: if (flush || commit) begin
                    state <= DRAIN;
                    pend  <= commit;
                    dcnt  <= '0;
                end
                DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                    if (drain_done) state <= pend ? SWAP : RUN;
                end
                SWAP: begin
                    fir_a <= sa;
                    fir_b <= sb;
                    fir_c <= sc;
                    pend  <= 1'b0;
                    state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIR_SEQ_CTRL_STATS_EN
    logic swap_entry;
    assign swap_entry = (state == IDLE && commit) || (drain_done && pend);

    always_ff @(posedge clk)
        if (rst || swap_entry) out_count <= '0;
        else if (pop && out_count != 16'hFFFF) out_count <= out_count + 16'd1;
`endif
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: scoreboard bench; a behavioural core model sits on the fir_* side and a sample-history reference predicts m_data.
module tb_fir_seq_ctrl;
    localparam int W = 8, L = 2, DL = 4, D = 4;

    logic clk = 0, rst = 1;
    logic cfg_we = 0, flush = 0, s_valid = 0, m_ready = 0;
    logic [1:0] cfg_addr = 0;
    logic [W-1:0] cfg_wdata = 0, s_data = 0;
    logic cfg_busy, s_ready, m_valid, fir_ce;
    logic [W-1:0] m_data, fir_x, fir_a, fir_b, fir_c, fir_y;

    int checks = 0, errors = 0, acc_cnt = 0, hn;
    logic [W-1:0] hist [$];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] ca = 0, cb = 0, cc = 0, ev;
    logic [W-1:0] x1, x2;
    logic [W-1:0] pipe [L];

    always #5 clk = ~clk;

    fir_seq_ctrl #(.DATA_W(W), .LATENCY(L), .DRAIN_LEN(DL), .OUT_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_busy(cfg_busy), .flush(flush), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .fir_ce(fir_ce), .fir_x(fir_x),
        .fir_a(fir_a), .fir_b(fir_b), .fir_c(fir_c), .fir_y(fir_y)
    );

    function automatic logic [W-1:0] fir3(input logic [W-1:0] a, b, c, x0, xa, xb);
        int s;
        s = int'($signed(a)) * int'($signed(x0)) + int'($signed(b)) * int'($signed(xa))
          + int'($signed(c)) * int'($signed(xb));
        return W'(s >>> 4);
    endfunction

    // Core: result for the sample presented on a ce appears L ce-cycles later
    assign fir_y = pipe[L-1];
    always @(posedge clk)
        if (rst) begin
            x1 <= 0;
            x2 <= 0;
            for (int i = 0; i < L; i++) pipe[i] <= 0;
        end else if (fir_ce) begin
            pipe[0] <= fir3(fir_a, fir_b, fir_c, fir_x, x1, x2);
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
            x1 <= fir_x;
            x2 <= x1;
        end

    // Reference: expected result from the stream of core inputs the bench has caused
    always @(negedge clk)
        if (!rst && s_valid && s_ready) begin
            hn = hist.size();
            exp_q.push_back(fir3(ca, cb, cc, s_data, hn > 0 ? hist[hn-1] : 8'h0, hn > 1 ? hist[hn-2] : 8'h0));
            hist.push_back(s_data);
            acc_cnt++;
        end

    always @(negedge clk)
        if (!rst && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_beat got %h required none", m_data);
            end else begin
                ev = exp_q.pop_front();
                if (m_data !== ev) begin
                    errors++;
                    $display("FAIL out_data got %h required %h", m_data, ev);
                end
            end
        end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, got, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [W-1:0] d);
        cfg_we = 1;
        cfg_addr = a;
        cfg_wdata = d;
        tick();
        cfg_we = 0;
    endtask

    task automatic send(input logic [W-1:0] x);
        int k;
        s_valid = 1;
        s_data = x;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (s_ready) break;
        end
        tick();
        s_valid = 0;
        if (k == 60) chk("send_timeout", 0, 1);
    endtask

    task automatic zeros;
        for (int i = 0; i < DL; i++) hist.push_back(8'h0);
    endtask

    task automatic drain_watch;
        for (int i = 0; i < DL; i++) begin
            @(negedge clk);
            chk("drain_ce", fir_ce, 1);
            chk("drain_x", fir_x, 0);
            chk("drain_busy", cfg_busy, 1);
            chk("drain_ready", s_ready, 0);
        end
        tick();
    endtask

    task automatic flush_drain;
        flush = 1;
        s_valid = 1;
        @(negedge clk);
        chk("flush_blocks_ready", s_ready, 0);
        zeros();
        tick();
        flush = 0;
        s_valid = 0;
        drain_watch();
        @(negedge clk);
        chk("post_drain_ce", fir_ce, 0);
        chk("post_drain_busy", cfg_busy, 0);
        tick();
    endtask

    task automatic wait_empty;
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_valid) break;
        end
        chk("results_delivered", k < 200, 1);
        repeat (3) @(negedge clk);
        chk("no_extra_valid", m_valid, 0);
        tick();
    endtask

    initial begin
        repeat (3) tick();
        rst = 0;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_ce", fir_ce, 0);
        chk("rst_x", fir_x, 0);
        chk("rst_a", fir_a, 0);
        tick();

        cfg(0, 8'h08);
        cfg(1, 8'hE8);
        cfg(2, 8'h20);
        @(negedge clk);
        chk("idle_busy", cfg_busy, 0);
        chk("idle_ready", s_ready, 0);
        tick();
        cfg(3, 8'h00);
        @(negedge clk);
        chk("swap_busy", cfg_busy, 1);
        chk("swap_ce", fir_ce, 0);
        chk("swap_a_old", fir_a, 0);
        tick();
        @(negedge clk);
        chk("run_busy", cfg_busy, 0);
        chk("act_a", fir_a, 8'h08);
        chk("act_b", fir_b, 8'hE8);
        chk("act_c", fir_c, 8'h20);
        chk("run_ready", s_ready, 1);
        tick();
        ca = 8'h08; cb = 8'hE8; cc = 8'h20;
        m_ready = 1;

        send(8'h10);
        flush_drain();
        wait_empty();

        send(8'hB0);
        send(8'hC0);
        send(8'hD0);
        flush_drain();
        wait_empty();

        m_ready = 0;
        acc_cnt = 0;
        fork
            for (int i = 0; i < 6; i++) send(W'($urandom_range(0, 255)));
            begin
                repeat (12) @(negedge clk);
                chk("bp_accepts", acc_cnt, 4);
                chk("bp_ready_low", s_ready, 0);
                @(posedge clk);
                #1 m_ready = 1;
                @(negedge clk);
                @(negedge clk);
                chk("bp_ready_recover", s_ready, 1);
            end
        join
        flush_drain();
        wait_empty();

        cfg(0, 8'h10);
        cfg(1, 8'h04);
        cfg(2, 8'hFC);
        send(8'h30);
        send(8'hE0);
        cfg(3, 8'h00);
        zeros();
        fork
            drain_watch();
            cfg(0, 8'h7F);
        join
        @(negedge clk);
        chk("commit_swap_busy", cfg_busy, 1);
        chk("commit_swap_ce", fir_ce, 0);
        chk("commit_swap_ready", s_ready, 0);
        tick();
        @(negedge clk);
        chk("commit_busy_low", cfg_busy, 0);
        chk("commit_a", fir_a, 8'h10);
        chk("commit_b", fir_b, 8'h04);
        chk("commit_c", fir_c, 8'hFC);
        tick();
        wait_empty();
        ca = 8'h10; cb = 8'h04; cc = 8'hFC;

        for (int i = 0; i < 80; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data = W'($urandom_range(0, 255));
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        s_valid = 0;
        m_ready = 1;
        flush_drain();
        wait_empty();

        send(8'h55);
        send(8'hAA);
        flush = 1;
        tick();
        flush = 0;
        tick();
        rst = 1;
        exp_q.delete();
        hist.delete();
        tick();
        rst = 0;
        @(negedge clk);
        chk("rst2_m_valid", m_valid, 0);
        chk("rst2_s_ready", s_ready, 0);
        chk("rst2_busy", cfg_busy, 0);
        chk("rst2_ce", fir_ce, 0);
        chk("rst2_a", fir_a, 0);
        chk("rst2_b", fir_b, 0);
        chk("rst2_c", fir_c, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running required finished");
        $fatal(1);
    end
endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
Sequencer and configuration front-end for the 3-tap Q4.4 FIR core. The core computes y[n] = a·x[n] + b·x[n-1] + c·x[n-2] and advances only on fir_ce.
- Accepts coefficient writes into shadow registers and commits them atomically on a clean, drained delay line.
- Accepts a valid/ready sample stream and feeds it to the core.
- Tracks core latency, returns results through an output FIFO with credit-based backpressure.

Parameters:
DATA_W, 8, sample/coefficient width (signed Q4.4 at default)
LATENCY, 2, core ce-cycles from fir_x presented to matching fir_y valid (>=1)
DRAIN_LEN, 4, zero samples inserted per drain (must be >= LATENCY+2)
OUT_DEPTH, 4, output FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
cfg_we  in  1  coefficient/commit write strobe
cfg_addr  in  2  0=a, 1=b, 2=c, 3=commit (data ignored)
cfg_wdata  in  DATA_W  coefficient value
cfg_busy  out  1  high in DRAIN/SWAP; writes ignored while high
flush  in  1  request drain of the delay line (level-sampled in RUN)
s_valid  in  1  input sample valid
s_ready  out  1  input sample accepted when s_valid&s_ready
s_data  in  DATA_W  input sample
m_valid  out  1  output FIFO not empty
m_ready  in  1  output consumer ready
m_data  out  DATA_W  FIFO head (first-word-fall-through)
fir_ce  out  1  core clock enable
fir_x  out  DATA_W  core sample input
fir_a, fir_b, fir_c  out  DATA_W  active coefficients to core
fir_y  in  DATA_W  core result

Behaviour:
- Reset values:
  - state=IDLE; shadow and active coefficients 0.
  - fir_ce=0, fir_x=0, s_ready=0, m_valid=0, cfg_busy=0.
  - FIFO empty, credits=0, tag pipe cleared.
  - Reset mid-operation discards in-flight and FIFO data.
- Shadow writes (addr 0-2) take effect the next cycle when not busy.
- Commit (addr 3):
  - IDLE -> SWAP.
  - RUN -> DRAIN, then SWAP.
  - DRAIN/SWAP: ignored.
- IDLE:
  - s_ready=0, fir_ce=0.
- RUN:
  - s_ready = (credits < OUT_DEPTH).
  - On accept: fir_ce=1, fir_x=s_data that cycle, tag=1. Otherwise fir_ce=0.
  - flush=1 -> DRAIN; flush wins over sample acceptance that cycle (s_ready forced 0).
- DRAIN:
  - s_ready=0.
  - DRAIN_LEN consecutive cycles with fir_ce=1, fir_x=0, tag=0.
  - Exits to SWAP if a commit is pending, else RUN.
- SWAP:
  - One cycle; active<=shadow, fir_ce=0; then RUN.
  - Pending-commit flag cleared.
- Tag pipe:
  - LATENCY-bit shift register, advances only when fir_ce=1.
  - When fir_ce=1 and the last stage=1, fir_y is pushed into the FIFO on that edge.
- Credits = FIFO occupancy + in-flight tags.
  - +1 on accept, -1 on m_valid&m_ready; simultaneous events net 0.
  - Credits never exceed OUT_DEPTH, so FIFO overflow is impossible.
- Results of accepted samples stay in the core until further samples or a drain supply ce pulses. A flush is needed to retrieve the tail.
- Arithmetic is entirely inside the core; the controller never modifies data or coefficients.

Optional Feature:
- Macro FIR_SEQ_CTRL_STATS_EN.
- Defined: adds output port out_count (16 bits).
  - Increments on each m_valid&m_ready handshake.
  - Saturates at 0xFFFF.
  - Cleared by rst and on entry to SWAP.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, write a=0x08, b=0xE8, c=0x20, commit -> IDLE->SWAP->RUN; fir_a/b/c=08/E8/20; cfg_busy low except the SWAP cycle.
- Impulse: s_data=0x10 then flush -> FIFO outputs 0x08 only (one accepted sample); DRAIN lasts exactly 4 fir_ce cycles with fir_x=0.
- Stream 0xB0,0xC0,0xD0 (-5,-4,-3), then flush -> 3 outputs in order matching y=a·x[n]+b·x[n-1]+c·x[n-2]; no extra m_valid beats.
- Hold m_ready=0 and send 6 samples -> s_ready drops after 4 accepts (credits=4). Raise m_ready -> s_ready recovers next cycle; no data lost.
- Commit while RUN with 2 samples in flight -> DRAIN then SWAP. Both old results use the old coefficients; cfg writes during DRAIN are ignored (shadow unchanged).
- Assert rst during DRAIN -> next cycle state=IDLE, m_valid=0, fir_a/b/c=0, s_ready=0.
